addsub_slice_ctrl: RTL and testbench

ADDSUB_SLICE_CTRL -- requirements
Module: addsub_slice_ctrl

---
 rtl/addsub_pkg.sv | 7 +
 rtl/full_adder_array.sv | 18 +
 rtl/addsub_slice_ctrl.sv | 102 ++++++++++
 tb/tb_addsub_slice_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: FSM state type and slice-count helper shared by addsub_slice_ctrl
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int num_slices(input int op_width, input int slice_width);
    return op_width / slice_width;
  endfunction
endpackage

// File: rtl/full_adder_array.sv
// full_adder_array: ADDER_WIDTH-bit ripple chain of full adders
module full_adder_array #(
  parameter int ADDER_WIDTH = 8
) (
  input  logic [ADDER_WIDTH-1:0] a_in,
  input  logic [ADDER_WIDTH-1:0] b_in,
  input  logic                   c_in,
  output logic [ADDER_WIDTH-1:0] s_out,
  output logic                   c_out
);
  logic [ADDER_WIDTH:0] c;
  assign c[0] = c_in;
  for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_fa
    assign s_out[i] = a_in[i] ^ b_in[i] ^ c[i];
    assign c[i+1]   = (a_in[i] & b_in[i]) | (c[i] & (a_in[i] ^ b_in[i]));
  end
  assign c_out = c[ADDER_WIDTH];
endmodule

// File: rtl/addsub_slice_ctrl.sv
// addsub_slice_ctrl: multi-cycle add/subtract, one SLICE_WIDTH slice per cycle, LS slice first.
// Defining ADDSUB_OVF_EN adds the signed-overflow output ovf_out.
module addsub_slice_ctrl
  import addsub_pkg::*;
#(
  parameter int OP_WIDTH    = 32,
  parameter int SLICE_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_in,
  output logic                req_ready_out,
  input  logic [OP_WIDTH-1:0] a_in,
  input  logic [OP_WIDTH-1:0] b_in,
  input  logic                sub_in,
  output logic                rsp_valid_out,
  input  logic                rsp_ready_in,
  output logic [OP_WIDTH-1:0] sum_out,
`ifdef ADDSUB_OVF_EN
  output logic                ovf_out,
`endif
  output logic                cout_out
);
  localparam int N = num_slices(OP_WIDTH, SLICE_WIDTH);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  if (OP_WIDTH % SLICE_WIDTH != 0) begin : g_width_check
    $error("OP_WIDTH must be an integer multiple of SLICE_WIDTH");
  end
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, sub_q, sub_d;
  logic [OP_WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [SLICE_WIDTH-1:0] a_sl, b_sl, s_sl;
  logic c_sl, accept, run, last;
  assign accept = req_valid_in && req_ready_out;
  assign run    = state_q == RUN;
  assign last   = run && cnt_q == LAST;
  // subtract is A + ~B + 1: the +1 comes from the carry register preloaded with sub_in
  assign a_sl = a_q[cnt_q*SLICE_WIDTH +: SLICE_WIDTH];
  assign b_sl = b_q[cnt_q*SLICE_WIDTH +: SLICE_WIDTH] ^ {SLICE_WIDTH{sub_q}};
  full_adder_array #(.ADDER_WIDTH(SLICE_WIDTH)) u_fa (
    .a_in  (a_sl),
    .b_in  (b_sl),
    .c_in  (carry_q),
    .s_out (s_sl),
    .c_out (c_sl)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = req_valid_in ? RUN : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      DONE:    state_d = rsp_ready_in ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready_out = state_q == IDLE;
    rsp_valid_out = state_q == DONE;
  end
  always_comb begin
    a_d     = accept ? a_in : a_q;
    b_d     = accept ? b_in : b_q;
    sub_d   = accept ? sub_in : sub_q;
    cnt_d   = accept ? '0 : run ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    carry_d = accept ? sub_in : run ? c_sl : carry_q;
    sum_d   = accept ? '0 : sum_q;
    if (run) sum_d[cnt_q*SLICE_WIDTH +: SLICE_WIDTH] = s_sl;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
    end
  assign sum_out  = sum_q;
  assign cout_out = carry_q;
`ifdef ADDSUB_OVF_EN
  logic ovf_q, ovf_d;
  // carry into the MSB is recovered from the MSB sum bit of the last slice
  assign ovf_d = last ? (a_sl[SLICE_WIDTH-1] ^ b_sl[SLICE_WIDTH-1] ^ s_sl[SLICE_WIDTH-1]) ^ c_sl
                      : ovf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  assign ovf_out = ovf_q;
`endif
endmodule

// File: tb/tb_addsub_slice_ctrl.sv
// tb_addsub_slice_ctrl: scoreboard bench for an 8-bit-slice and a 32-bit-slice instance
module tb_addsub_slice_ctrl;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld[2], rdy[2], rv[2], rr[2], sb[2], co[2];
  logic [W-1:0] a[2], b[2], s[2];
`ifdef ADDSUB_OVF_EN
  logic ov[2];
`endif
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit seen[2];
  exp_t q0[$];
  exp_t q1[$];

  for (genvar i = 0; i < 2; i++) begin : g_dut
    addsub_slice_ctrl #(.OP_WIDTH(W), .SLICE_WIDTH(i == 0 ? 8 : 32)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_in  (vld[i]),
      .req_ready_out (rdy[i]),
      .a_in          (a[i]),
      .b_in          (b[i]),
      .sub_in        (sb[i]),
      .rsp_valid_out (rv[i]),
      .rsp_ready_in  (rr[i]),
      .sum_out       (s[i]),
`ifdef ADDSUB_OVF_EN
      .ovf_out       (ov[i]),
`endif
      .cout_out      (co[i])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // rv first rises in the cycle after edge acc+N, i.e. cyc == acc+N at that negedge
  task automatic monitor(input int d);
    exp_t e;
    if (rst_n && rv[d]) begin
      if ((d == 1 ? q1.size() : q0.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp dut%0d: got rsp_valid with empty scoreboard", d);
      end else begin
        e = d == 1 ? q1[0] : q0[0];
        if (!seen[d]) begin
          seen[d] = 1'b1;
          chk($sformatf("latency_dut%0d", d), 64'(cyc - e.acc), d == 1 ? 64'd1 : 64'd4);
        end
        chk($sformatf("sum_dut%0d", d), 64'(s[d]), 64'(e.sum));
        chk($sformatf("cout_dut%0d", d), 64'(co[d]), 64'(e.cout));
`ifdef ADDSUB_OVF_EN
        chk($sformatf("ovf_dut%0d", d), 64'(ov[d]), 64'(e.ovf));
`endif
        chk($sformatf("ready_in_done_dut%0d", d), 64'(rdy[d]), 64'd0);
        if (rr[d]) begin
          seen[d] = 1'b0;
          if (d == 1) q1.delete(0);
          else q0.delete(0);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  // call at posedge+1 or at a negedge; returns at posedge+1 after the accept edge
  task automatic issue(input int d, input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    int n = 0;
    vld[d] = 1'b1;
    a[d] = av;
    b[d] = bv;
    sb[d] = sv;
    while (!rdy[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: req_ready_out got 0 required 1", d);
    end else begin
      e = '{sum: es, cout: ec, ovf: eo, acc: cyc + 1};
      if (d == 1) q1.push_back(e);
      else q0.push_back(e);
    end
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
    a[d] = ~av;
    b[d] = ~bv;
    sb[d] = ~sv;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
    chk("drain_pending", 64'(q0.size() + q1.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm, input int d);
    chk({nm, "_ready"}, 64'(rdy[d]), 64'd1);
    chk({nm, "_valid"}, 64'(rv[d]), 64'd0);
    chk({nm, "_sum"}, 64'(s[d]), 64'd0);
    chk({nm, "_cout"}, 64'(co[d]), 64'd0);
`ifdef ADDSUB_OVF_EN
    chk({nm, "_ovf"}, 64'(ov[d]), 64'd0);
`endif
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0;
      rr[d] = 1'b1;
      a[d] = '0;
      b[d] = '0;
      sb[d] = 1'b0;
    end
    #12;
    chk_idle("reset0", 0);
    chk_idle("reset1", 1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    issue(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(0, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    issue(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    issue(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    issue(0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    drain();
    rr[0] = 1'b0;
    issue(0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 32'hDFAE_BFF0, 1'b0, 1'b0);
    fork
      begin
        for (int i = 0; i < 50 && !rv[0]; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        rr[0] = 1'b1;
      end
      issue(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    join
    drain();
    issue(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    issue(1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    drain();
    vld[0] = 1'b1;
    a[0] = 32'hAAAA_AAAA;
    b[0] = 32'h5555_5555;
    sb[0] = 1'b0;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("abort0", 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_rsp", 64'(rv[0]), 64'd0);
    issue(0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0002, 1'b0, 1'b0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
